alu_seq: RTL and testbench
==========================

# alu_seq

Registered, parametrised successor to the combinational 8-bit datapath ALU. It executes the 8085-style arithmetic, logic and rotate set, plus a multi-cycle shift-add multiply. A valid/ready handshake sits on the input and a one-cycle result strobe on the output. It owns an architectural flag register (S, Z, AC, P, CY), so carry-chained ops (ADC, SBB, RAL, RAR) need no external carry path.

## Interface
Parameters:
- WIDTH, 8, operand/result width; legal values ≥ 8 (AC is always taken at bit 3/4).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- op_valid  in  1  request present.
- op_ready  out  1  block can accept; high only in IDLE.
- op  in  4  operation code (see Operation).
- a  in  WIDTH  accumulator operand.
- b  in  WIDTH  second operand.
- res_valid  out  1  one-cycle strobe; result/result_hi/flags are new.
- result  out  WIDTH  result (low word for MUL).
- result_hi  out  WIDTH  high word of MUL; 0 for all other ops.
- flags  out  5  {S,Z,AC,P,CY}, bit 4..0.
- flag_wr  in  1  load flag register from flag_din (PSW restore).
- flag_din  in  5  flag value for flag_wr.

## Operation
- Codes: 0 ADD, 1 ADC, 2 SUB, 3 SBB, 4 AND, 5 OR, 6 XOR, 7 CMP, 8 NOT, 9 RLC, 10 RRC, 11 RAL, 12 RAR, 13 INC, 14 DEC, 15 MUL.
- Arithmetic is modulo 2^WIDTH.
  - CY = carry out of the MSB for adds; CY = borrow for SUB/SBB/CMP.
  - ADC and SBB use the registered CY as carry-in/borrow-in.
- AC:
  - Carry from bit 3 to bit 4 for ADD/ADC/INC.
  - Borrow from bit 4 into bit 3 for SUB/SBB/CMP/DEC.
  - 0 for logical ops.
- Flag rules:
  - Z = (result == 0); S = result[WIDTH-1].
  - P = 1 when result has an even number of ones.
  - These apply to every op except those listed below.
- Flag exceptions:
  - AND/OR/XOR: CY=0, AC=0.
  - CMP: result = a (unchanged); flags are taken from a−b.
  - NOT: result = ~a; all flags unchanged.
  - INC/DEC: result = a±1; CY unchanged.
  - RLC/RRC: rotate; CY = bit rotated out.
  - RAL/RAR: rotate through CY.
  - All rotates leave S, Z, AC and P unchanged.
  - MUL (unsigned a×b): {result_hi,result} = product; S, Z, P from the low word; CY = |result_hi; AC = 0.
- FSM states:
  - IDLE: accept on op_valid & op_ready. Single-cycle op → stay in IDLE. MUL → go to MUL.
  - MUL: one shift-add iteration per cycle, WIDTH iterations; on the last one → IDLE.
- flag_wr is honoured in any state. If it coincides with an op completion, flag_din wins over computed flags; result still updates.
- result and result_hi hold their value until the next completion.

## Timing
- Reset: state=IDLE, result=0, result_hi=0, res_valid=0, flags=0, iteration counter=0. op_valid and flag_wr are ignored while rst=1.
- op_ready = (state==IDLE), combinational from state; it is 1 in the cycle after the reset edge.
- Single-cycle op accepted at edge E0:
  - result, flags and res_valid are registered at E0, so res_valid is high for the cycle after E0.
  - Back-to-back acceptance every cycle is allowed. ADC/SBB use the CY produced by the previous op.
- MUL accepted at E0:
  - op_ready is low from E0; iterations run at E1..E(WIDTH).
  - Product, flags and res_valid are registered at E(WIDTH); op_ready is high again in the same cycle as res_valid.
  - Latency is WIDTH cycles, throughput 1/WIDTH.
- Reset mid-MUL: abort with no res_valid; all outputs return to their reset values at that edge.
- op_valid in MUL state is not accepted; the requester holds a, b and op until op_ready.

## Structure
- Package alu_pkg holds:
  - the op-code enum (4-bit);
  - flag bit indices FLG_CY=0, FLG_P=1, FLG_AC=2, FLG_Z=3, FLG_S=4;
  - the FSM state enum.
- One sub-module: alu_mul_seq, WIDTH-parametrised shift-add multiplier with start/done and a counter. The top keeps the FSM, the single-cycle datapath and the flag register.

## Test plan
- ADD a=8'hFF, b=8'h01 → result 00, res_valid 1 cycle after accept, flags S0 Z1 AC1 P1 CY1.
- SUB a=8'h05, b=8'h07 → FE, S1 Z0 P0 CY1. Then CMP a=8'h05, b=8'h05 → result 05, Z1 CY0.
- flag_wr with CY=1, then ADC 8'h10+8'h20 → 31, CY0. Then RAR with flags CY=1, a=8'h02 → 81, CY0, S/Z/AC/P unchanged.
- MUL 8'hFF×8'hFF → result 01, result_hi FE, CY1 Z0 P0 S0.
  - res_valid exactly 8 cycles after the accept edge.
  - op_ready low through the MUL, high with res_valid.
- MUL accepted, rst at the third iteration → no res_valid, flags 00000, op_ready 1 next cycle. A following ADD 8'h01+8'h01 → 02.
- op_valid held high with 6 consecutive single-cycle ops → 6 consecutive res_valid cycles in order, no bubbles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential 8085-style ALU: op codes, flag bit
// positions and FSM states.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_ADC = 4'd1,
        OP_SUB = 4'd2,
        OP_SBB = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6,
        OP_CMP = 4'd7,
        OP_NOT = 4'd8,
        OP_RLC = 4'd9,
        OP_RRC = 4'd10,
        OP_RAL = 4'd11,
        OP_RAR = 4'd12,
        OP_INC = 4'd13,
        OP_DEC = 4'd14,
        OP_MUL = 4'd15
    } op_e;

    localparam int FLG_CY = 0;
    localparam int FLG_P  = 1;
    localparam int FLG_AC = 2;
    localparam int FLG_Z  = 3;
    localparam int FLG_S  = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier, one iteration per step; the product of the
// final iteration is presented combinationally together with done.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               step,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]      cnt_r;
    logic [WIDTH-1:0]   mcand_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] acc_s;
    logic [WIDTH:0]     sum_s;

    // One iteration: conditionally add multiplicand into the upper half, then shift right
    always_comb begin
        sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
              + (acc_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
        acc_s = {sum_s, acc_r[WIDTH-1:1]};
    end

    assign done    = step && (cnt_r == CW'(WIDTH - 1));
    assign product = acc_s;

    // Operand capture on start, iteration state on each step
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= {CW{1'b0}};
            mcand_r <= {WIDTH{1'b0}};
            acc_r   <= {(2*WIDTH){1'b0}};
        end else if (start) begin
            cnt_r   <= {CW{1'b0}};
            mcand_r <= mcand;
            acc_r   <= {{WIDTH{1'b0}}, mplier};
        end else if (step) begin
            cnt_r   <= cnt_r + CW'(1);
            acc_r   <= acc_s;
        end else begin
            cnt_r   <= cnt_r;
            acc_r   <= acc_r;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered 8085-style ALU with valid/ready input, one-cycle result strobe,
// an architectural flag register and a multi-cycle shift-add multiply.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             res_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [4:0]       flags,
    input  logic             flag_wr,
    input  logic [4:0]       flag_din
);

    function automatic logic even_parity(input logic [WIDTH-1:0] v);
        return ~(^v);
    endfunction

    state_e             state_r, state_s;
    op_e                op_s;
    logic [4:0]         flags_r;
    logic               accept_s, mul_start_s, mul_step_s, mul_done_s;
    logic [2*WIDTH-1:0] mul_prod_s;
    logic [WIDTH-1:0]   opnd_s, res_s, fval_s;
    logic               ci_s, sub_s, cy_s, ac_s, upd_szp_s;
    logic [WIDTH:0]     sum_s;
    logic [4:0]         flg_s, mul_flg_s;

    assign op_s       = op_e'(op);
    assign op_ready   = (state_r == ST_IDLE);
    assign accept_s   = op_valid && op_ready;
    assign mul_step_s = (state_r == ST_MUL);
    assign flags      = flags_r;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start_s),
        .step    (mul_step_s),
        .mcand   (a),
        .mplier  (b),
        .done    (mul_done_s),
        .product (mul_prod_s)
    );

    // Shared adder/subtractor operand, carry-in and direction selection
    always_comb begin
        opnd_s = b;
        ci_s   = 1'b0;
        sub_s  = 1'b0;
        case (op_s)
            OP_ADC: ci_s = flags_r[FLG_CY];
            OP_SUB, OP_CMP: sub_s = 1'b1;
            OP_SBB: begin
                sub_s = 1'b1;
                ci_s  = flags_r[FLG_CY];
            end
            OP_INC: opnd_s = {{(WIDTH-1){1'b0}}, 1'b1};
            OP_DEC: begin
                opnd_s = {{(WIDTH-1){1'b0}}, 1'b1};
                sub_s  = 1'b1;
            end
            default: ci_s = 1'b0;
        endcase
        if (sub_s) begin
            sum_s = {1'b0, a} - {1'b0, opnd_s} - {{WIDTH{1'b0}}, ci_s};
        end else begin
            sum_s = {1'b0, a} + {1'b0, opnd_s} + {{WIDTH{1'b0}}, ci_s};
        end
    end

    // Single-cycle result and flag selection; the bit-4 xor recovers the nibble carry/borrow
    always_comb begin
        res_s     = sum_s[WIDTH-1:0];
        cy_s      = sum_s[WIDTH];
        ac_s      = a[4] ^ opnd_s[4] ^ sum_s[4];
        upd_szp_s = 1'b1;
        case (op_s)
            OP_ADD, OP_ADC, OP_SUB, OP_SBB: res_s = sum_s[WIDTH-1:0];
            OP_CMP: res_s = a;
            OP_INC, OP_DEC: cy_s = flags_r[FLG_CY];
            OP_AND, OP_OR, OP_XOR: begin
                res_s = (op_s == OP_AND) ? (a & b) : ((op_s == OP_OR) ? (a | b) : (a ^ b));
                cy_s  = 1'b0;
                ac_s  = 1'b0;
            end
            OP_NOT: begin
                res_s     = ~a;
                cy_s      = flags_r[FLG_CY];
                ac_s      = flags_r[FLG_AC];
                upd_szp_s = 1'b0;
            end
            OP_RLC, OP_RAL: begin
                res_s     = {a[WIDTH-2:0], (op_s == OP_RLC) ? a[WIDTH-1] : flags_r[FLG_CY]};
                cy_s      = a[WIDTH-1];
                ac_s      = flags_r[FLG_AC];
                upd_szp_s = 1'b0;
            end
            OP_RRC, OP_RAR: begin
                res_s     = {(op_s == OP_RRC) ? a[0] : flags_r[FLG_CY], a[WIDTH-1:1]};
                cy_s      = a[0];
                ac_s      = flags_r[FLG_AC];
                upd_szp_s = 1'b0;
            end
            default: res_s = sum_s[WIDTH-1:0];
        endcase
        fval_s        = (op_s == OP_CMP) ? sum_s[WIDTH-1:0] : res_s;
        flg_s         = flags_r;
        flg_s[FLG_CY] = cy_s;
        flg_s[FLG_AC] = ac_s;
        flg_s[FLG_S]  = upd_szp_s ? fval_s[WIDTH-1] : flags_r[FLG_S];
        flg_s[FLG_Z]  = upd_szp_s ? (fval_s == {WIDTH{1'b0}}) : flags_r[FLG_Z];
        flg_s[FLG_P]  = upd_szp_s ? even_parity(fval_s) : flags_r[FLG_P];
    end

    // Multiply flags: S/Z/P from the low word, CY marks a non-zero high word
    always_comb begin
        mul_flg_s         = 5'b00000;
        mul_flg_s[FLG_S]  = mul_prod_s[WIDTH-1];
        mul_flg_s[FLG_Z]  = (mul_prod_s[WIDTH-1:0] == {WIDTH{1'b0}});
        mul_flg_s[FLG_P]  = even_parity(mul_prod_s[WIDTH-1:0]);
        mul_flg_s[FLG_CY] = |mul_prod_s[2*WIDTH-1:WIDTH];
    end

    // Next-state logic; a multiply leaves IDLE and returns on its last iteration
    always_comb begin
        state_s     = state_r;
        mul_start_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (op_valid && (op_s == OP_MUL)) begin
                    state_s     = ST_MUL;
                    mul_start_s = 1'b1;
                end else begin
                    state_s     = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_done_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_MUL;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Result, strobe and flag registers; an explicit flag write overrides computed flags
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            result    <= {WIDTH{1'b0}};
            result_hi <= {WIDTH{1'b0}};
            flags_r   <= 5'b00000;
        end else begin
            res_valid <= 1'b0;
            if (accept_s && (op_s != OP_MUL)) begin
                res_valid <= 1'b1;
                result    <= res_s;
                result_hi <= {WIDTH{1'b0}};
                flags_r   <= flg_s;
            end else if (mul_done_s) begin
                res_valid <= 1'b1;
                result    <= mul_prod_s[WIDTH-1:0];
                result_hi <= mul_prod_s[2*WIDTH-1:WIDTH];
                flags_r   <= mul_flg_s;
            end else begin
                result    <= result;
                result_hi <= result_hi;
            end
            if (flag_wr) begin
                flags_r <= flag_din;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq (WIDTH=8) with hand-computed
// expectations plus sequences for multiply latency, reset abort and streaming.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       op_valid;
    logic       op_ready;
    logic [3:0] op;
    logic [7:0] a, b;
    logic       res_valid;
    logic [7:0] result, result_hi;
    logic [4:0] flags;
    logic       flag_wr;
    logic [4:0] flag_din;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [4:0] pre;
        logic [7:0] res;
        logic [7:0] res_hi;
        logic [4:0] flg;
    } vec_t;

    vec_t vecs[19];
    vec_t seq[6];

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .res_valid (res_valid),
        .result    (result),
        .result_hi (result_hi),
        .flags     (flags),
        .flag_wr   (flag_wr),
        .flag_din  (flag_din)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Preload flags, issue one op, wait for its strobe and compare everything
    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        int rdy_early;
        flag_wr  = 1'b1;
        flag_din = v.pre;
        tick();
        flag_wr  = 1'b0;
        check({tag, " strobe_low"}, 32'(res_valid), 32'd0);
        check({tag, " ready"}, 32'(op_ready), 32'd1);
        op_valid = 1'b1;
        op = v.op;
        a  = v.a;
        b  = v.b;
        tick();
        op_valid = 1'b0;
        if (v.op == 4'd15) begin
            lat = 0;
            rdy_early = 0;
            while (!res_valid && lat < 32) begin
                if (op_ready) rdy_early++;
                tick();
                lat++;
            end
            check({tag, " mul_latency"}, 32'(lat), 32'd8);
            check({tag, " ready_during_mul"}, 32'(rdy_early), 32'd0);
        end
        check({tag, " res_valid"}, 32'(res_valid), 32'd1);
        check({tag, " ready_with_result"}, 32'(op_ready), 32'd1);
        check({tag, " result"}, 32'(result), 32'(v.res));
        check({tag, " result_hi"}, 32'(result_hi), 32'(v.res_hi));
        check({tag, " flags"}, 32'(flags), 32'(v.flg));
    endtask

    initial begin
        int rv_seen;
        //           op     a      b      pre       res    hi     {S,Z,AC,P,CY}
        vecs[0]  = '{4'd0,  8'hFF, 8'h01, 5'b00000, 8'h00, 8'h00, 5'b01111};
        vecs[1]  = '{4'd2,  8'h05, 8'h07, 5'b00000, 8'hFE, 8'h00, 5'b10101};
        vecs[2]  = '{4'd7,  8'h05, 8'h05, 5'b00000, 8'h05, 8'h00, 5'b01010};
        vecs[3]  = '{4'd1,  8'h10, 8'h20, 5'b00001, 8'h31, 8'h00, 5'b00000};
        vecs[4]  = '{4'd12, 8'h02, 8'h00, 5'b11111, 8'h81, 8'h00, 5'b11110};
        vecs[5]  = '{4'd4,  8'hF0, 8'h3C, 5'b11111, 8'h30, 8'h00, 5'b00010};
        vecs[6]  = '{4'd5,  8'h0F, 8'hF0, 5'b00000, 8'hFF, 8'h00, 5'b10010};
        vecs[7]  = '{4'd6,  8'hAA, 8'hAA, 5'b11111, 8'h00, 8'h00, 5'b01010};
        vecs[8]  = '{4'd8,  8'h55, 8'h00, 5'b10101, 8'hAA, 8'h00, 5'b10101};
        vecs[9]  = '{4'd9,  8'h80, 8'h00, 5'b00000, 8'h01, 8'h00, 5'b00001};
        vecs[10] = '{4'd10, 8'h01, 8'h00, 5'b11110, 8'h80, 8'h00, 5'b11111};
        vecs[11] = '{4'd11, 8'h80, 8'h00, 5'b00000, 8'h00, 8'h00, 5'b00001};
        vecs[12] = '{4'd13, 8'h0F, 8'h00, 5'b00001, 8'h10, 8'h00, 5'b00101};
        vecs[13] = '{4'd14, 8'h10, 8'h00, 5'b00000, 8'h0F, 8'h00, 5'b00110};
        vecs[14] = '{4'd3,  8'h10, 8'h05, 5'b00001, 8'h0A, 8'h00, 5'b00110};
        vecs[15] = '{4'd14, 8'h00, 8'h00, 5'b00000, 8'hFF, 8'h00, 5'b10110};
        vecs[16] = '{4'd15, 8'hFF, 8'hFF, 5'b00000, 8'h01, 8'hFE, 5'b00001};
        vecs[17] = '{4'd15, 8'h10, 8'h03, 5'b11111, 8'h30, 8'h00, 5'b00010};
        vecs[18] = '{4'd1,  8'hFF, 8'h00, 5'b00001, 8'h00, 8'h00, 5'b01111};

        // back-to-back stream, carry chained through the flag register
        seq[0] = '{4'd0, 8'h01, 8'h02, 5'b00000, 8'h03, 8'h00, 5'b00010};
        seq[1] = '{4'd0, 8'hFF, 8'h02, 5'b00000, 8'h01, 8'h00, 5'b00101};
        seq[2] = '{4'd1, 8'h01, 8'h01, 5'b00000, 8'h03, 8'h00, 5'b00010};
        seq[3] = '{4'd2, 8'h00, 8'h01, 5'b00000, 8'hFF, 8'h00, 5'b10111};
        seq[4] = '{4'd3, 8'h05, 8'h01, 5'b00000, 8'h03, 8'h00, 5'b00010};
        seq[5] = '{4'd6, 8'h0F, 8'hFF, 5'b00000, 8'hF0, 8'h00, 5'b10010};

        rst = 1'b1;
        op_valid = 1'b0;
        op = 4'd0;
        a = 8'h00;
        b = 8'h00;
        flag_wr = 1'b1;
        flag_din = 5'b11111;
        repeat (3) tick();
        rst = 1'b0;
        flag_wr = 1'b0;

        check("reset op_ready", 32'(op_ready), 32'd1);
        check("reset res_valid", 32'(res_valid), 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset result_hi", 32'(result_hi), 32'd0);
        check("reset flags", 32'(flags), 32'd0);

        for (int i = 0; i < 19; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // reset during the third multiply iteration aborts with no strobe
        flag_wr  = 1'b1;
        flag_din = 5'b10101;
        tick();
        flag_wr  = 1'b0;
        op_valid = 1'b1;
        op = 4'd15;
        a  = 8'hFF;
        b  = 8'hFF;
        tick();
        op_valid = 1'b0;
        check("abort busy", 32'(op_ready), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort res_valid", 32'(res_valid), 32'd0);
        check("abort flags", 32'(flags), 32'd0);
        check("abort op_ready", 32'(op_ready), 32'd1);
        check("abort result", 32'(result), 32'd0);
        check("abort result_hi", 32'(result_hi), 32'd0);
        rv_seen = 0;
        repeat (10) begin
            tick();
            if (res_valid) rv_seen++;
        end
        check("abort no late strobe", 32'(rv_seen), 32'd0);
        run_vec('{4'd0, 8'h01, 8'h01, 5'b00000, 8'h02, 8'h00, 5'b00000}, "post_abort_add");

        // flag write coinciding with a completion wins over the computed flags
        flag_wr  = 1'b1;
        flag_din = 5'b10011;
        op_valid = 1'b1;
        op = 4'd0;
        a  = 8'h01;
        b  = 8'h01;
        tick();
        flag_wr  = 1'b0;
        op_valid = 1'b0;
        check("flag_wr_coincide res_valid", 32'(res_valid), 32'd1);
        check("flag_wr_coincide result", 32'(result), 32'h02);
        check("flag_wr_coincide flags", 32'(flags), 32'h13);
        tick();

        // six single-cycle ops with op_valid held high: one strobe per cycle
        op_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            op = seq[i].op;
            a  = seq[i].a;
            b  = seq[i].b;
            tick();
            check($sformatf("b2b%0d res_valid", i), 32'(res_valid), 32'd1);
            check($sformatf("b2b%0d result", i), 32'(result), 32'(seq[i].res));
            check($sformatf("b2b%0d flags", i), 32'(flags), 32'(seq[i].flg));
        end
        op_valid = 1'b0;
        tick();
        check("b2b strobe drops", 32'(res_valid), 32'd0);
        check("result holds", 32'(result), 32'hF0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
